ifetch_unit: RTL

- Instruction fetch stage directly upstream of the control decoder. It holds the PC and fetches one 32-bit word per instruction from an instruction memory with a request/grant/response handshake.
- It presents the word to the decoder with a valid/ready handshake.
- When the instruction retires, it computes the next PC from the decoder's nPC_sel encoding and the ALU zero flag.
- No branch delay slot; one instruction in flight at a time.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/npc_calc.sv | 42 ++++
 rtl/ifetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared between the fetch stage and the control decoder.
//   - next-PC select encoding (same values the decoder drives on npc_sel)
//   - fetch FSM state type
//   - default first-fetch address
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_BEQ = 2'b10;
  localparam logic [1:0] NPC_BNE = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC computation for the retiring instruction.
//   pc       in  32  address of the retiring instruction
//   inst     in  32  retiring instruction word (jump index / branch offset)
//   npc_sel  in  2   next-PC select (seq / jump / beq / bne)
//   alu_zero in  1   ALU zero flag of the retiring instruction
//   npc      out 32  next PC, all arithmetic mod 2^32
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [1:0]  npc_sel,
  input  logic        alu_zero,
  output logic [31:0] npc
);

  logic [31:0] pc4_s;
  logic [31:0] br_off_s;
  logic [31:0] br_tgt_s;

  // Select the next PC; the branch target is relative to pc+4 (no delay slot).
  always_comb begin
    pc4_s    = pc + 32'd4;
    br_off_s = {{14{inst[15]}}, inst[15:0], 2'b00};
    br_tgt_s = pc4_s + br_off_s;
    npc      = pc4_s;
    case (npc_sel)
      NPC_SEQ: npc = pc4_s;
      NPC_J:   npc = {pc4_s[31:28], inst[25:0], 2'b00};
      NPC_BEQ: begin
        if (alu_zero) npc = br_tgt_s;
        else          npc = pc4_s;
      end
      NPC_BNE: begin
        if (!alu_zero) npc = br_tgt_s;
        else           npc = pc4_s;
      end
      default: npc = pc4_s;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-issue instruction fetch stage.
//   clk, rst_n                     clock, async active-low reset
//   imem_req/imem_addr/imem_gnt    fetch request handshake to instruction memory
//   imem_rvalid/imem_rdata/imem_err read response (err qualified by rvalid)
//   inst/inst_valid/inst_ready     instruction handoff to the decoder
//   pc                             address of inst
//   npc_sel/alu_zero               next-PC control, sampled on the consume edge
//   halt                           stop fetching after the current instruction retires
//   fetch_err                      sticky bus-error flag; the block parks until reset
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        alu_zero,
  input  logic        halt,
  output logic        fetch_err
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("ifetch_unit: RESET_PC must be word aligned");
  end

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  npc_s;

  // With one instruction in flight the fetch address always equals the held pc,
  // so a single register drives both outputs.
  assign pc        = pc_r;
  assign imem_addr = pc_r;

  npc_calc u_npc_calc (
    .pc       (pc_r),
    .inst     (inst),
    .npc_sel  (npc_sel),
    .alu_zero (alu_zero),
    .npc      (npc_s)
  );

  // Fetch FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      imem_req   <= 1'b0;
      inst       <= 32'h0000_0000;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r  <= ST_REQ;
          imem_req <= 1'b1;
        end
        // The request stays up (halt cannot retract it) until granted.
        ST_REQ: begin
          if (imem_gnt) begin
            state_r  <= ST_WAIT;
            imem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (imem_err) begin
              fetch_err <= 1'b1;
              state_r   <= ST_ERR;
            end else begin
              inst       <= imem_rdata;
              inst_valid <= 1'b1;
              state_r    <= ST_HOLD;
            end
          end
        end
        // inst_valid is always 1 here, so ready alone marks the consume edge.
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            pc_r       <= npc_s;
            if (halt) begin
              state_r <= ST_HALTED;
            end else begin
              state_r  <= ST_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (!halt) begin
            state_r  <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_ERR: begin
          state_r  <= ST_ERR;
          imem_req <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
